// File: rtl/sum_prod_pkg.sv
// Shared types and constants for the sequential sum-of-products datapath.
package sum_prod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam int unsigned NUM_OPS  = 6;
    localparam int unsigned NUM_PROD = 3;

    // Accumulator width: three 2N-bit products need two extra carry bits.
    function automatic int unsigned res_width(input int unsigned n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/mult_nxn.sv
// Purely combinational unsigned N x N multiplier producing a 2N-bit product.
module mult_nxn #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    always_comb begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    end

endmodule

// File: rtl/sum_prod_seq.sv
// Resource-shared X0*X1 + X2*X3 + X4*X5: one multiplier reused over three cycles,
// valid/ready on both the operand input and the result output.
module sum_prod_seq
    import sum_prod_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            X [NUM_OPS-1:0],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [res_width(N)-1:0] result,
    output logic                    busy
);

    localparam int unsigned RW   = res_width(N);
    localparam logic [1:0]  LAST = 2'(NUM_PROD - 1);

    state_t          state;
    state_t          next_state;
    logic [1:0]      cnt;
    logic [N-1:0]    opreg [NUM_OPS-1:0];
    logic [RW-1:0]   acc;
    logic [RW-1:0]   acc_next;
    logic [RW-1:0]   result_q;
    logic [N-1:0]    mul_a;
    logic [N-1:0]    mul_b;
    logic [2*N-1:0]  product;
    logic            accept;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = MUL;
            MUL:  if (cnt == LAST) next_state = DONE;
            DONE: begin
                if (out_ready) begin
                    next_state = accept ? MUL : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs; in DONE a new set is accepted only together with consuming the result
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            MUL:  busy     = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (cnt)
            2'd0: begin
                mul_a = opreg[0];
                mul_b = opreg[1];
            end
            2'd1: begin
                mul_a = opreg[2];
                mul_b = opreg[3];
            end
            default: begin
                mul_a = opreg[4];
                mul_b = opreg[5];
            end
        endcase
    end

    mult_nxn #(.N(N)) u_mult (
        .a (mul_a),
        .b (mul_b),
        .p (product)
    );

    always_comb begin
        acc_next = acc + {2'b00, product};
    end

    // result has its own register so it holds the last sum while acc restarts
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            result_q <= '0;
            for (int unsigned i = 0; i < NUM_OPS; i++) begin
                opreg[i] <= '0;
            end
        end else if (accept) begin
            cnt <= '0;
            acc <= '0;
            for (int unsigned i = 0; i < NUM_OPS; i++) begin
                opreg[i] <= X[i];
            end
        end else if (state == MUL) begin
            acc <= acc_next;
            if (cnt == LAST) begin
                cnt      <= '0;
                result_q <= acc_next;
            end else begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    assign result = result_q;

endmodule
